io_device_endpoint: RTL and testbench

- Device-side partner of the machine's I/O electronic unit; stands in for the tape reader (input) and the tape punch/printer (output).
- Answers the unit's input handshake (rdy/val) and output handshake (rdy/ack) on 5-bit symbols.
- Buffers symbols in two FIFOs exchanged with a host-side valid/ready stream (bench, UART bridge or panel logic).
- Programmable delays emulate mechanical device speed.

---
 rtl/io_device_endpoint.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_io_device_endpoint.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_device_endpoint.sv
// Device-side endpoint for the I/O unit: emulates tape reader (input) and punch (output)
// with host-facing FIFOs and programmable mechanical delays.

module io_ep_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push_i,
  input  logic [4:0]    push_data_i,
  input  logic          pop_i,
  output logic [4:0]    head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [4:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= push_data_i;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

module io_device_endpoint #(
  parameter int FIFO_DEPTH  = 8,
  parameter int READ_DELAY  = 4,
  parameter int PUNCH_DELAY = 4,
  parameter int CW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          input_rdy,
  output logic          input_val,
  output logic [4:0]    input_data,
  input  logic          output_rdy,
  input  logic [4:0]    output_data,
  output logic          output_ack,
  input  logic          host_in_valid,
  output logic          host_in_ready,
  input  logic [4:0]    host_in_data,
  output logic          host_out_valid,
  input  logic          host_out_ready,
  output logic [4:0]    host_out_data,
  output logic [CW-1:0] in_count,
  output logic [CW-1:0] out_count
);
  localparam int MAXD = (READ_DELAY > PUNCH_DELAY) ? READ_DELAY : PUNCH_DELAY;
  localparam int DW   = $clog2(MAXD + 2);

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_DLY = 2'd1, R_VAL = 2'd2} rd_state_e;
  typedef enum logic [1:0] {P_IDLE = 2'd0, P_DLY = 2'd1, P_ACK = 2'd2} pn_state_e;

  rd_state_e     rd_state_q, rd_state_d;
  logic [DW-1:0] rd_cnt_q, rd_cnt_d;
  logic          val_q, val_d;
  logic [4:0]    data_q, data_d;
  logic          rd_pop;

  pn_state_e     pn_state_q, pn_state_d;
  logic [DW-1:0] pn_cnt_q, pn_cnt_d;
  logic          ack_q, ack_d;
  logic [4:0]    hold_q, hold_d;
  logic          pn_push;

  logic [4:0]    in_head;
  logic          in_full, in_empty;
  logic          out_full, out_empty;

  io_ep_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_in_fifo (
    .clk(clk), .resetn(resetn),
    .push_i(host_in_valid), .push_data_i(host_in_data),
    .pop_i(rd_pop), .head_o(in_head), .count_o(in_count),
    .full_o(in_full), .empty_o(in_empty)
  );

  io_ep_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_out_fifo (
    .clk(clk), .resetn(resetn),
    .push_i(pn_push), .push_data_i(hold_q),
    .pop_i(host_out_ready), .head_o(host_out_data), .count_o(out_count),
    .full_o(out_full), .empty_o(out_empty)
  );

  assign host_in_ready  = !in_full;
  assign host_out_valid = !out_empty;
  assign input_val      = val_q;
  assign input_data     = data_q;
  assign output_ack     = ack_q;

  // Reader state and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_state_q <= R_IDLE;
      rd_cnt_q   <= '0;
      val_q      <= 1'b0;
      data_q     <= 5'd0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_cnt_q   <= rd_cnt_d;
      val_q      <= val_d;
      data_q     <= data_d;
    end
  end

  // Reader next state: a withdrawn request returns to idle without consuming the symbol.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    case (rd_state_q)
      R_IDLE: begin
        if (input_rdy && !in_empty) begin
          rd_state_d = R_DLY;
          rd_cnt_d   = DW'(READ_DELAY);
        end else begin
          rd_state_d = R_IDLE;
        end
      end
      R_DLY: begin
        if (!input_rdy) begin
          rd_state_d = R_IDLE;
          rd_cnt_d   = '0;
        end else if (rd_cnt_q == '0) begin
          rd_state_d = R_VAL;
        end else begin
          rd_cnt_d = rd_cnt_q - DW'(1);
        end
      end
      R_VAL: begin
        if (!input_rdy) begin
          rd_state_d = R_IDLE;
        end else begin
          rd_state_d = R_VAL;
        end
      end
      default: begin
        rd_state_d = R_IDLE;
        rd_cnt_d   = '0;
      end
    endcase
  end

  // Reader outputs: the head is popped only once the unit has dropped its request.
  always_comb begin
    val_d  = val_q;
    data_d = data_q;
    rd_pop = 1'b0;
    case (rd_state_q)
      R_DLY: begin
        if (input_rdy && (rd_cnt_q == '0)) begin
          val_d  = 1'b1;
          data_d = in_head;
        end else begin
          val_d = 1'b0;
        end
      end
      R_VAL: begin
        if (!input_rdy) begin
          val_d  = 1'b0;
          rd_pop = 1'b1;
        end else begin
          val_d = 1'b1;
        end
      end
      default: begin
        val_d = 1'b0;
      end
    endcase
  end

  // Punch state, hold register and registered acknowledge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pn_state_q <= P_IDLE;
      pn_cnt_q   <= '0;
      ack_q      <= 1'b0;
      hold_q     <= 5'd0;
    end else begin
      pn_state_q <= pn_state_d;
      pn_cnt_q   <= pn_cnt_d;
      ack_q      <= ack_d;
      hold_q     <= hold_d;
    end
  end

  // Punch next state: a full output FIFO leaves the unit's request unanswered.
  always_comb begin
    pn_state_d = pn_state_q;
    pn_cnt_d   = pn_cnt_q;
    case (pn_state_q)
      P_IDLE: begin
        if (output_rdy && !out_full) begin
          pn_state_d = P_DLY;
          pn_cnt_d   = DW'(PUNCH_DELAY);
        end else begin
          pn_state_d = P_IDLE;
        end
      end
      P_DLY: begin
        if (!output_rdy) begin
          pn_state_d = P_IDLE;
          pn_cnt_d   = '0;
        end else if (pn_cnt_q == '0) begin
          pn_state_d = P_ACK;
        end else begin
          pn_cnt_d = pn_cnt_q - DW'(1);
        end
      end
      P_ACK: begin
        if (!output_rdy) begin
          pn_state_d = P_IDLE;
        end else begin
          pn_state_d = P_ACK;
        end
      end
      default: begin
        pn_state_d = P_IDLE;
        pn_cnt_d   = '0;
      end
    endcase
  end

  // Punch outputs: the slot reserved at entry guarantees the push cannot overflow.
  always_comb begin
    ack_d   = ack_q;
    hold_d  = hold_q;
    pn_push = 1'b0;
    case (pn_state_q)
      P_IDLE: begin
        ack_d = 1'b0;
        if (output_rdy && !out_full) begin
          hold_d = output_data;
        end else begin
          hold_d = hold_q;
        end
      end
      P_DLY: begin
        if (output_rdy && (pn_cnt_q == '0)) begin
          ack_d   = 1'b1;
          pn_push = 1'b1;
        end else begin
          ack_d = 1'b0;
        end
      end
      P_ACK: begin
        if (!output_rdy) begin
          ack_d = 1'b0;
        end else begin
          ack_d = 1'b1;
        end
      end
      default: begin
        ack_d = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_io_device_endpoint.sv
// Bench for io_device_endpoint: directed handshake steps on a delay-4 instance and a
// randomized loop on a delay-0 instance, both checked against scoreboard queues.

module tb_io_device_endpoint;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       a_resetn, a_input_rdy, a_output_rdy, a_host_in_valid, a_host_out_ready;
  logic [4:0] a_output_data, a_host_in_data;
  logic       a_input_val, a_output_ack, a_host_in_ready, a_host_out_valid;
  logic [4:0] a_input_data, a_host_out_data;
  logic [3:0] a_in_count, a_out_count;

  logic       b_resetn, b_input_rdy, b_output_rdy, b_host_in_valid, b_host_out_ready;
  logic [4:0] b_output_data, b_host_in_data;
  logic       b_input_val, b_output_ack, b_host_in_ready, b_host_out_valid;
  logic [4:0] b_input_data, b_host_out_data;
  logic [3:0] b_in_count, b_out_count;

  logic [4:0] a_exp_in[$];
  logic [4:0] a_exp_out[$];
  logic [4:0] b_exp_in[$];
  logic [4:0] b_exp_out[$];
  bit         rnd_done;

  io_device_endpoint #(.FIFO_DEPTH(8), .READ_DELAY(4), .PUNCH_DELAY(4)) dut_a (
    .clk(clk), .resetn(a_resetn),
    .input_rdy(a_input_rdy), .input_val(a_input_val), .input_data(a_input_data),
    .output_rdy(a_output_rdy), .output_data(a_output_data), .output_ack(a_output_ack),
    .host_in_valid(a_host_in_valid), .host_in_ready(a_host_in_ready), .host_in_data(a_host_in_data),
    .host_out_valid(a_host_out_valid), .host_out_ready(a_host_out_ready), .host_out_data(a_host_out_data),
    .in_count(a_in_count), .out_count(a_out_count)
  );

  io_device_endpoint #(.FIFO_DEPTH(8), .READ_DELAY(0), .PUNCH_DELAY(0)) dut_b (
    .clk(clk), .resetn(b_resetn),
    .input_rdy(b_input_rdy), .input_val(b_input_val), .input_data(b_input_data),
    .output_rdy(b_output_rdy), .output_data(b_output_data), .output_ack(b_output_ack),
    .host_in_valid(b_host_in_valid), .host_in_ready(b_host_in_ready), .host_in_data(b_host_in_data),
    .host_out_valid(b_host_out_valid), .host_out_ready(b_host_out_ready), .host_out_data(b_host_out_data),
    .in_count(b_in_count), .out_count(b_out_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic a_push(input logic [4:0] sym);
    check("push_ready", a_host_in_ready, 1);
    a_host_in_valid = 1'b1;
    a_host_in_data  = sym;
    a_exp_in.push_back(sym);
    tick();
    a_host_in_valid = 1'b0;
  endtask

  // Full read handshake; the first tick is the edge that samples the request.
  task automatic a_read(input int cnt_before);
    int n;
    logic [4:0] e;
    a_input_rdy = 1'b1;
    n = 0;
    while (!a_input_val && n < 20) begin
      tick();
      n++;
    end
    check("read_val_latency", n - 1, 5);
    if (a_exp_in.size() == 0) begin
      check("read_sb_empty", 0, 1);
    end else begin
      e = a_exp_in.pop_front();
      check("read_data", a_input_data, e);
    end
    check("read_count_held", a_in_count, cnt_before);
    tick();
    check("read_val_held", a_input_val, 1);
    a_input_rdy = 1'b0;
    tick();
    check("read_val_drop", a_input_val, 0);
    check("read_count_pop", a_in_count, cnt_before - 1);
  endtask

  task automatic a_punch(input logic [4:0] sym);
    int n;
    a_output_rdy  = 1'b1;
    a_output_data = sym;
    n = 0;
    while (!a_output_ack && n < 20) begin
      tick();
      n++;
    end
    check("punch_ack_latency", n - 1, 5);
    a_exp_out.push_back(sym);
    tick();
    a_output_rdy = 1'b0;
    tick();
    check("punch_ack_drop", a_output_ack, 0);
  endtask

  task automatic a_pop();
    logic [4:0] e;
    check("pop_valid", a_host_out_valid, 1);
    if (a_exp_out.size() == 0) begin
      check("pop_sb_empty", 0, 1);
    end else begin
      e = a_exp_out.pop_front();
      check("pop_data", a_host_out_data, e);
    end
    a_host_out_ready = 1'b1;
    tick();
    a_host_out_ready = 1'b0;
  endtask

  initial begin
    int n;
    bit saw;
    a_resetn = 1'b0; a_input_rdy = 1'b0; a_output_rdy = 1'b0; a_output_data = 5'd0;
    a_host_in_valid = 1'b0; a_host_in_data = 5'd0; a_host_out_ready = 1'b0;
    b_resetn = 1'b0; b_input_rdy = 1'b0; b_output_rdy = 1'b0; b_output_data = 5'd0;
    b_host_in_valid = 1'b0; b_host_in_data = 5'd0; b_host_out_ready = 1'b0;
    rnd_done = 1'b0;
    tick(); tick();
    a_resetn = 1'b1;
    b_resetn = 1'b1;
    check("post_reset_in_ready", a_host_in_ready, 1);
    check("post_reset_out_valid", a_host_out_valid, 0);

    // Reset while both handshakes are active.
    a_host_in_valid = 1'b1; a_host_in_data = 5'h11;
    tick();
    a_host_in_valid = 1'b0;
    a_input_rdy = 1'b1; a_output_rdy = 1'b1; a_output_data = 5'h05;
    repeat (8) tick();
    check("pre_reset_val", a_input_val, 1);
    check("pre_reset_ack", a_output_ack, 1);
    a_resetn = 1'b0;
    tick();
    check("reset_val", a_input_val, 0);
    check("reset_ack", a_output_ack, 0);
    check("reset_data", a_input_data, 0);
    check("reset_in_count", a_in_count, 0);
    check("reset_out_count", a_out_count, 0);
    check("reset_in_ready", a_host_in_ready, 1);
    check("reset_out_valid", a_host_out_valid, 0);
    a_input_rdy = 1'b0; a_output_rdy = 1'b0; a_resetn = 1'b1;
    tick();

    // Three symbols through the reader, in order.
    a_push(5'h13); a_push(5'h06); a_push(5'h07);
    check("in_count_3", a_in_count, 3);
    a_read(3); a_read(2); a_read(1);
    a_input_rdy = 1'b1;
    saw = 1'b0;
    repeat (10) begin
      tick();
      saw = saw | a_input_val;
    end
    check("no_fourth_val", saw, 0);
    a_input_rdy = 1'b0;
    tick();

    // Single punch, then fill the output FIFO to capacity.
    a_punch(5'h1F);
    check("out_count_1", a_out_count, 1);
    check("out_head_1f", a_host_out_data, 5'h1F);
    for (int i = 1; i < 8; i++) a_punch(5'(i + 8));
    check("out_count_full", a_out_count, 8);
    a_output_rdy = 1'b1; a_output_data = 5'h0A;
    saw = 1'b0;
    repeat (12) begin
      tick();
      saw = saw | a_output_ack;
    end
    check("full_no_ack", saw, 0);
    check("full_count", a_out_count, 8);
    a_pop();
    n = 0;
    while (!a_output_ack && n < 20) begin
      tick();
      n++;
    end
    check("unstall_ack_latency", n - 1, 5);
    a_exp_out.push_back(5'h0A);
    a_output_rdy = 1'b0;
    tick();
    check("refill_count", a_out_count, 8);
    repeat (8) a_pop();
    check("drain_count", a_out_count, 0);
    check("drain_sb_empty", a_exp_out.size(), 0);

    // Request withdrawn during the delay; the head symbol stays queued.
    a_push(5'h15); a_push(5'h02);
    a_input_rdy = 1'b1;
    saw = 1'b0;
    repeat (3) begin
      tick();
      saw = saw | a_input_val;
    end
    a_input_rdy = 1'b0;
    repeat (8) begin
      tick();
      saw = saw | a_input_val;
    end
    check("withdraw_no_val", saw, 0);
    check("withdraw_count", a_in_count, 2);
    a_read(2); a_read(1);

    // Zero-delay instance: concurrent random host and unit traffic.
    fork
      begin
        fork
          begin
            int i, guard;
            logic rdy_now, v;
            logic [4:0] s;
            i = 0; guard = 0;
            while (i < 100 && guard < 5000) begin
              rdy_now = b_host_in_ready;
              v = 1'($urandom_range(0, 1));
              s = 5'($urandom_range(0, 31));
              b_host_in_valid = v;
              b_host_in_data  = s;
              tick();
              guard++;
              if (v && rdy_now) begin
                b_exp_in.push_back(s);
                i++;
              end
            end
            b_host_in_valid = 1'b0;
            check("rnd_push_done", i, 100);
          end
          begin
            int got, w;
            bit ok;
            logic [4:0] e;
            got = 0; ok = 1'b1;
            while (got < 100 && ok) begin
              b_input_rdy = 1'b1;
              w = 0;
              while (!b_input_val && w < 300) begin
                tick();
                w++;
              end
              if (!b_input_val) begin
                check("rnd_val_timeout", 0, 1);
                ok = 1'b0;
              end else begin
                if (b_exp_in.size() == 0) begin
                  check("rnd_in_sb_empty", 0, 1);
                end else begin
                  e = b_exp_in.pop_front();
                  check("rnd_in_data", b_input_data, e);
                end
                got++;
                repeat ($urandom_range(0, 2)) tick();
                b_input_rdy = 1'b0;
                tick();
                repeat ($urandom_range(0, 1)) tick();
              end
            end
            b_input_rdy = 1'b0;
            check("rnd_read_done", got, 100);
          end
          begin
            int sent, w;
            bit ok;
            sent = 0; ok = 1'b1;
            while (sent < 100 && ok) begin
              b_output_data = 5'($urandom_range(0, 31));
              b_output_rdy  = 1'b1;
              w = 0;
              while (!b_output_ack && w < 300) begin
                tick();
                w++;
              end
              if (!b_output_ack) begin
                check("rnd_ack_timeout", 0, 1);
                ok = 1'b0;
              end else begin
                b_exp_out.push_back(b_output_data);
                sent++;
                repeat ($urandom_range(0, 2)) tick();
                b_output_rdy = 1'b0;
                tick();
                repeat ($urandom_range(0, 1)) tick();
              end
            end
            b_output_rdy = 1'b0;
            check("rnd_punch_done", sent, 100);
          end
          begin
            int got, guard;
            logic vnow, r;
            logic [4:0] dnow, e;
            got = 0; guard = 0;
            while (got < 100 && guard < 6000) begin
              vnow = b_host_out_valid;
              dnow = b_host_out_data;
              r = 1'($urandom_range(0, 1));
              b_host_out_ready = r;
              tick();
              guard++;
              if (vnow && r) begin
                if (b_exp_out.size() == 0) begin
                  check("rnd_out_sb_empty", 0, 1);
                end else begin
                  e = b_exp_out.pop_front();
                  check("rnd_out_data", dnow, e);
                end
                got++;
              end
            end
            b_host_out_ready = 1'b0;
            check("rnd_pop_done", got, 100);
          end
        join
        rnd_done = 1'b1;
      end
      begin
        logic pv;
        logic [4:0] pd;
        pv = 1'b0; pd = 5'd0;
        while (!rnd_done) begin
          @(negedge clk);
          if (pv) begin
            check("rnd_val_stable", b_input_val, 1);
            check("rnd_data_stable", b_input_data, pd);
          end
          pv = b_input_rdy && b_input_val;
          pd = b_input_data;
        end
      end
    join
    repeat (3) tick();
    check("rnd_in_count_end", b_in_count, 0);
    check("rnd_out_count_end", b_out_count, 0);
    check("rnd_in_sb_end", b_exp_in.size(), 0);
    check("rnd_out_sb_end", b_exp_out.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
